// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with a three-state miss sequencer.
// Hits resolve in IDLE with zero stall; misses optionally write back the victim, then fetch.
module dcache_controller #(
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_BYTES = 4,
  parameter int ADDR_W      = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                READ,
  input  logic                WRITE,
  input  logic [ADDR_W-1:0]   ADDRESS,
  input  logic [7:0]          WRITEDATA,
  output logic [7:0]          READDATA,
  output logic                BUSYWAIT,
  output logic                MEM_READ,
  output logic                MEM_WRITE,
  output logic [ADDR_W-3:0]   MEM_ADDRESS,
  output logic [31:0]         MEM_WRITEDATA,
  input  logic [31:0]         MEM_READDATA,
  input  logic                MEM_BUSYWAIT
);
  localparam int OW = $clog2(BLOCK_BYTES);
  localparam int IW = $clog2(NUM_BLOCKS);
  localparam int TW = ADDR_W - OW - IW;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t state, nxt;

  logic [NUM_BLOCKS-1:0]                       valid, dirty;
  logic [NUM_BLOCKS-1:0][TW-1:0]               tags;
  logic [NUM_BLOCKS-1:0][BLOCK_BYTES-1:0][7:0] data;
  logic [7:0]                                  rdata_q;

  logic [OW-1:0] offset;
  logic [IW-1:0] idx;
  logic [TW-1:0] atag;
  logic          req, hit, rd_hit, wr_hit, fill, wb_done;

  assign offset = ADDRESS[OW-1:0];
  assign idx    = ADDRESS[OW +: IW];
  assign atag   = ADDRESS[ADDR_W-1 -: TW];
  assign req    = READ | WRITE;
  assign hit    = valid[idx] && (tags[idx] == atag);
  assign rd_hit = (state == IDLE) && READ  && hit;
  assign wr_hit = (state == IDLE) && WRITE && hit;

  // Read hits are served combinationally; otherwise the last read byte is held.
  assign READDATA = rd_hit ? data[idx][offset] : rdata_q;

  always_comb begin
    nxt           = state;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    fill          = 1'b0;
    wb_done       = 1'b0;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          // gated by RESET so the stall drops while reset is held with a request pending
          BUSYWAIT = RESET;
          nxt      = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tags[idx], idx};
        MEM_WRITEDATA = data[idx];
        BUSYWAIT      = 1'b1;
        if (!MEM_BUSYWAIT) begin
          nxt     = FETCH;
          wb_done = 1'b1;
        end
      end
      FETCH: begin
        if (!req) begin
          nxt = IDLE;
        end else begin
          MEM_READ    = 1'b1;
          MEM_ADDRESS = {atag, idx};
          BUSYWAIT    = 1'b1;
          if (!MEM_BUSYWAIT) begin
            nxt  = IDLE;
            fill = 1'b1;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      valid   <= '0;
      dirty   <= '0;
      rdata_q <= '0;
    end else begin
      state <= nxt;
      if (rd_hit)  rdata_q    <= data[idx][offset];
      if (wr_hit)  dirty[idx] <= 1'b1;
      if (wb_done) dirty[idx] <= 1'b0;
      if (fill) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset; valid bits gate every use of it.
  always_ff @(posedge CLK) begin
    if (wr_hit) data[idx][offset] <= WRITEDATA;
    if (fill) begin
      data[idx] <= MEM_READDATA;
      tags[idx] <= atag;
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: hit vectors from a table, miss/writeback/reset sequences by hand.
module tb_dcache_controller;
  localparam int LAT = 5;

  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;

  always #5 CLK = ~CLK;

  dcache_controller dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  // Word memory: busy for LAT cycles after a strobe rises, completes on the following edge.
  logic [31:0] mem [64];
  logic        mem_loaded = 1'b0;
  int          cnt = 0;

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (cnt != LAT);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5_0000 | i;
      mem[0]     <= 32'h4433_2211;
      mem[7]     <= 32'h8765_4321;
      mem[8]     <= 32'h0D0C_0B0A;
      mem[9]     <= 32'h9999_9955;
      mem[15]    <= 32'h1122_3344;
      mem_loaded <= 1'b1;
    end
    if (MEM_READ | MEM_WRITE) begin
      if (cnt == LAT) begin
        cnt <= 0;
        if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Issue a request and hold it until BUSYWAIT falls; returns at the resolving hit cycle.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                        output int busy, output logic sw, output logic sr,
                        output logic [5:0] wb_addr, output logic [31:0] wb_data,
                        output logic [5:0] f_addr, output logic both);
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
    busy = 0; sw = 0; sr = 0; both = 0;
    wb_addr = '1; wb_data = '1; f_addr = '1;
    #1;
    while (BUSYWAIT && busy < 200) begin
      busy++;
      if (MEM_WRITE) begin sw = 1; wb_addr = MEM_ADDRESS; wb_data = MEM_WRITEDATA; end
      if (MEM_READ)  begin sr = 1; f_addr = MEM_ADDRESS; end
      if (MEM_READ && MEM_WRITE) both = 1;
      @(negedge CLK); #1;
    end
    chk("no_timeout", busy < 200, 1'b1);
  endtask

  typedef struct {
    logic       rd, wr;
    logic [7:0] a, wd, exp;
  } vec_t;
  vec_t tbl [6];

  int          busy;
  logic        sw, sr, both;
  logic [5:0]  wb_addr, f_addr;
  logic [31:0] wb_data;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'h03, 8'h00, 8'h44};
    tbl[1] = '{1'b1, 1'b0, 8'h02, 8'h00, 8'h33};
    tbl[2] = '{1'b0, 1'b1, 8'h01, 8'hAA, 8'h33};  // write hit: READDATA holds
    tbl[3] = '{1'b1, 1'b0, 8'h01, 8'h00, 8'hAA};
    tbl[4] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h11};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h11};  // idle: READDATA holds

    RESET = 0; READ = 0; WRITE = 0; ADDRESS = 0; WRITEDATA = 0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_readdata", READDATA, 8'h00);
    chk("rst_busywait", BUSYWAIT, 1'b0);
    chk("rst_strobes", {MEM_READ, MEM_WRITE}, 2'b00);
    chk("rst_mem_addr", MEM_ADDRESS, 6'h00);
    chk("rst_mem_wdata", MEM_WRITEDATA, 32'h0);
    @(negedge CLK); RESET = 1;

    // Cold read miss
    access(1, 0, 8'h00, 8'h00, busy, sw, sr, wb_addr, wb_data, f_addr, both);
    chk("m1_stall", busy, LAT + 2);
    chk("m1_no_wb", sw, 1'b0);
    chk("m1_fetch", sr, 1'b1);
    chk("m1_faddr", f_addr, 6'h00);
    chk("m1_rdata", READDATA, 8'h11);

    // Hit sequence
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      READ = tbl[i].rd; WRITE = tbl[i].wr; ADDRESS = tbl[i].a; WRITEDATA = tbl[i].wd;
      #1;
      chk($sformatf("hit%0d_busy", i), BUSYWAIT, 1'b0);
      chk($sformatf("hit%0d_strobes", i), {MEM_READ, MEM_WRITE}, 2'b00);
      chk($sformatf("hit%0d_rdata", i), READDATA, tbl[i].exp);
    end

    // Conflict miss on dirty line 0
    access(1, 0, 8'h20, 8'h00, busy, sw, sr, wb_addr, wb_data, f_addr, both);
    chk("m2_stall", busy, 2 * (LAT + 1) + 1);
    chk("m2_wb", sw, 1'b1);
    chk("m2_wb_addr", wb_addr, 6'h00);
    chk("m2_wb_data", wb_data, 32'h4433_AA11);
    chk("m2_faddr", f_addr, 6'h08);
    chk("m2_both", both, 1'b0);
    chk("m2_rdata", READDATA, 8'h0A);

    // Write miss on invalid line 7, then read back the merged line
    access(0, 1, 8'h1E, 8'h5C, busy, sw, sr, wb_addr, wb_data, f_addr, both);
    chk("m3_stall", busy, LAT + 2);
    chk("m3_no_wb", sw, 1'b0);
    chk("m3_faddr", f_addr, 6'h07);
    access(1, 0, 8'h1E, 8'h00, busy, sw, sr, wb_addr, wb_data, f_addr, both);
    chk("m3_rd_busy", busy, 0);
    chk("m3_rd_byte2", READDATA, 8'h5C);
    access(1, 0, 8'h1D, 8'h00, busy, sw, sr, wb_addr, wb_data, f_addr, both);
    chk("m3_rd_byte1", READDATA, 8'h43);

    // Evicting line 7 proves it went dirty
    access(1, 0, 8'h3C, 8'h00, busy, sw, sr, wb_addr, wb_data, f_addr, both);
    chk("m4_stall", busy, 2 * (LAT + 1) + 1);
    chk("m4_wb_addr", wb_addr, 6'h07);
    chk("m4_wb_data", wb_data, 32'h875C_4321);
    chk("m4_faddr", f_addr, 6'h0F);
    chk("m4_rdata", READDATA, 8'h44);

    // Dirty line 7 again, then abandon a fetch with reset
    access(0, 1, 8'h3D, 8'h77, busy, sw, sr, wb_addr, wb_data, f_addr, both);
    chk("wh_busy", busy, 0);
    @(negedge CLK);
    READ = 1; WRITE = 0; ADDRESS = 8'h24;
    repeat (3) @(negedge CLK);
    #1;
    chk("rs_pre_mem_read", MEM_READ, 1'b1);
    chk("rs_pre_busy", BUSYWAIT, 1'b1);
    #1 RESET = 0;
    #1;
    chk("rs_mem_read", MEM_READ, 1'b0);
    chk("rs_busy", BUSYWAIT, 1'b0);
    chk("rs_readdata", READDATA, 8'h00);
    @(negedge CLK);
    RESET = 1; READ = 0;

    access(1, 0, 8'h24, 8'h00, busy, sw, sr, wb_addr, wb_data, f_addr, both);
    chk("pr_stall", busy, LAT + 2);
    chk("pr_no_wb", sw, 1'b0);
    chk("pr_rdata", READDATA, 8'h55);
    access(1, 0, 8'h3C, 8'h00, busy, sw, sr, wb_addr, wb_data, f_addr, both);
    chk("pr7_stall", busy, LAT + 2);
    chk("pr7_no_wb", sw, 1'b0);
    chk("pr7_rdata", READDATA, 8'h44);

    @(negedge CLK);
    READ = 0; WRITE = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
